// File: rtl/serial_paralelo_rx_if.sv
// Serial lane bundle between a bit source and the byte recoverer.
//   data_in     : serial bit, MSB of each byte first
//   data_out    : last recovered non-idle byte
//   valid_out   : data_out holds a data byte for the current byte period
//   byte_strobe : one-cycle pulse per byte boundary while locked
//   active      : lane locked and delivering data
// master = bit source / consumer side, slave = receiver side.
interface serial_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active
  );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: finds byte alignment on the COM symbol,
// locks after LOCK_CNT consecutive aligned COMs, then delivers bytes.
//   clk_32f : serial-rate clock, rising edge
//   reset   : synchronous active-high reset
//   lane    : serial_paralelo_rx_if.slave (data_in in; data_out,
//             valid_out, byte_strobe, active out, all registered)
module serial_paralelo_rx #(
  parameter logic [7:0]  COM      = 8'hBC,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic                clk_32f,
  input  logic                reset,
  serial_paralelo_rx_if.slave lane
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned HIST_W    = BYTE_W - 1;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned COM_CNT_W = 4;

  localparam logic [COM_CNT_W-1:0] LOCK_TARGET = COM_CNT_W'(LOCK_CNT);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT    = BIT_CNT_W'(BYTE_W - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [HIST_W-1:0]      hist_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [COM_CNT_W-1:0]   com_cnt_q, com_cnt_d;
  logic [BYTE_W-1:0]      data_out_q, data_out_d;
  logic                   valid_q, valid_d;
  logic                   strobe_q, strobe_d;
  logic                   active_q;

  // Only the 7 newest bits need storing; the incoming bit completes the window.
  logic [BYTE_W-1:0] sr_next;
  logic              byte_done;

  assign sr_next   = {hist_q, lane.data_in};
  assign byte_done = (bit_cnt_q == LAST_BIT);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
    com_cnt_d  = com_cnt_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;

    case (state_q)
      SEARCH: begin
        valid_d   = 1'b0;
        bit_cnt_d = bit_cnt_q;
        if (sr_next == COM) begin
          bit_cnt_d = '0;
          com_cnt_d = COM_CNT_W'(1);
          state_d   = (LOCK_TARGET == COM_CNT_W'(1)) ? ACTIVE : ALIGN;
        end
      end

      ALIGN: begin
        valid_d = 1'b0;
        if (byte_done) begin
          if (sr_next == COM) begin
            // Saturating count; lock as soon as the target is reached.
            if (com_cnt_q < LOCK_TARGET) begin
              com_cnt_d = com_cnt_q + COM_CNT_W'(1);
            end
            if ((com_cnt_q + COM_CNT_W'(1)) >= LOCK_TARGET) begin
              state_d = ACTIVE;
            end
          end else begin
            com_cnt_d = '0;
            state_d   = SEARCH;
          end
        end
      end

      ACTIVE: begin
        if (byte_done) begin
          strobe_d = 1'b1;
          if (sr_next != COM) begin
            data_out_d = sr_next;
            valid_d    = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q    <= SEARCH;
      hist_q     <= '0;
      bit_cnt_q  <= '0;
      com_cnt_q  <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= sr_next[HIST_W-1:0];
      bit_cnt_q  <= bit_cnt_d;
      com_cnt_q  <= com_cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      active_q   <= (state_d == ACTIVE);
    end
  end

  assign lane.data_out    = data_out_q;
  assign lane.valid_out   = valid_q;
  assign lane.byte_strobe = strobe_q;
  assign lane.active      = active_q;

endmodule

// File: doc/serial_paralelo_rx.md
SERIAL_PARALELO_RX -- requirements
Module: serial_paralelo_rx

Interface
REQ-001 SHALL have port: clk_32f  input  1  serial-rate clock; the only clock, all logic on its rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on clk_32f rising edge.
REQ-003 SHALL have port: data_in  input  1  serial lane bit, MSB of each byte first.
REQ-004 SHALL have port: data_out  output  8  last recovered non-idle byte.
REQ-005 SHALL have port: valid_out  output  1  data_out holds a valid data byte for the current byte period.
REQ-006 SHALL have port: byte_strobe  output  1  one-cycle pulse marking each byte boundary while aligned.
REQ-007 SHALL have port: active  output  1  lane locked and delivering data.
REQ-008 SHALL have parameter: COM, default 8'hBC, alignment/idle symbol.
REQ-009 SHALL have parameter: LOCK_CNT, default 4, consecutive aligned COMs required for lock; legal range 1..15.

Function
REQ-010 SHALL shift every cycle: sr <= {sr[6:0], data_in}; sr_next denotes {sr[6:0], data_in}.
REQ-011 SHALL implement FSM states SEARCH, ALIGN, ACTIVE; a 3-bit bit_cnt; a 4-bit com_cnt.
REQ-012 In SEARCH, bit_cnt SHALL be don't-care; when sr_next == COM: go to ALIGN, bit_cnt <= 0, com_cnt <= 1 (if LOCK_CNT == 1 go directly to ACTIVE).
REQ-013 In ALIGN and ACTIVE, bit_cnt SHALL increment mod 8 every cycle; a byte completes on a cycle where bit_cnt == 7, byte value = sr_next.
REQ-014 In ALIGN, at byte completion: if byte == COM, com_cnt increments; on reaching LOCK_CNT go to ACTIVE.
REQ-015 In ALIGN, at byte completion with byte != COM: go to SEARCH, com_cnt <= 0; same-cycle COM re-detection is not required.
REQ-016 active SHALL be 1 exactly while state == ACTIVE (registered, asserts the cycle after the locking byte completes).
REQ-017 In ACTIVE, at byte completion, byte_strobe SHALL pulse 1 for the following cycle only; otherwise 0.
REQ-018 In ACTIVE, at byte completion with byte != COM: data_out <= byte, valid_out <= 1, both held for 8 cycles until next completion.
REQ-019 In ACTIVE, at byte completion with byte == COM: valid_out <= 0, data_out keeps previous value.
REQ-020 Latency SHALL be: data_out/valid_out update on the same edge that samples the byte's last bit.
REQ-021 ACTIVE SHALL be left only by reset; misaligned data in ACTIVE is passed through unchanged.
REQ-022 In SEARCH and ALIGN, valid_out and byte_strobe SHALL be 0.
REQ-023 com_cnt SHALL saturate at LOCK_CNT and never wrap.

Reset
REQ-024 With reset high at an edge: state <= SEARCH, sr <= 0, bit_cnt <= 0, com_cnt <= 0, data_out <= 0, valid_out <= 0, byte_strobe <= 0, active <= 0.
REQ-025 Reset SHALL take priority over all other activity, including mid-byte in ACTIVE; the data_in bit sampled at that edge is discarded.
REQ-026 After reset release, alignment SHALL restart from SEARCH with no memory of prior lock.

Verification
REQ-027 Reset, then serialize BC x4 then 8'h5A, 8'hC3 -> active rises 1 cycle after 4th BC completes; data_out = 5A with valid_out = 1 for 8 cycles, then C3.
REQ-028 Insert 3 random bits before BC x4 stream -> lock achieved at the shifted boundary; following bytes recovered correctly.
REQ-029 BC, BC, 8'h17, then BC x4 -> ALIGN aborts to SEARCH on 17; lock occurs only after the later 4 BCs; active = 0 throughout the first attempt.
REQ-030 In ACTIVE send 8'h11, BC, 8'h22 -> valid_out 1 (11), 0 (data_out still 11), 1 (22); byte_strobe pulses every 8 cycles.
REQ-031 Assert reset for 1 cycle mid-byte in ACTIVE -> all outputs 0 next cycle; relock needs 4 fresh BCs.
REQ-032 Constant all-zero or all-one input for 200 cycles after reset -> state stays SEARCH, active = 0, valid_out = 0.
